// File: rtl/seg_display_arbiter.sv
// Round-robin sequencer for the seven-segment driver: grants A or B, then converts
// the granted signed value to saturating sign/magnitude BCD one bit per cycle.
module seg_display_arbiter #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    output logic [9:0]        bcd_digit,
    output logic              sign,
    output logic              overflow,
    output logic              disp_src,
    output logic              busy,
    output logic              done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(DATA_W + 1);
    // Five digits so magnitudes up to 2^15 cannot wrap into a small-looking result.
    localparam int SCR_W = 20;

    state_t            state_r, state_s;
    logic              grant_s, win_b_s, last_step_s;
    logic              last_grant_r, src_r, sign_lat_r;
    logic [DATA_W-1:0] mag_r, win_data_s, abs_s;
    logic [SCR_W-1:0]  scr_r, adj_s, shifted_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              ovf_s;
    logic [9:0]        bcd_s;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Double-dabble step, saturation and operand selection.
    always_comb begin
        adj_s = '0;
        for (int i = 0; i < SCR_W / 4; i++) begin
            adj_s[4*i +: 4] = add3(scr_r[4*i +: 4]);
        end
        shifted_s = {adj_s[SCR_W-2:0], mag_r[DATA_W-1]};
        ovf_s     = (shifted_s[SCR_W-1:12] != '0) || (shifted_s[11:8] > 4'd3);
        if (ovf_s) begin
            bcd_s = 10'b11_1001_1001;
        end else begin
            bcd_s = shifted_s[9:0];
        end
        win_data_s = win_b_s ? data_b : data_a;
        if (win_data_s[DATA_W-1]) begin
            abs_s = ~win_data_s + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            abs_s = win_data_s;
        end
    end

    // Next-state logic and arbitration.
    always_comb begin
        state_s     = state_r;
        grant_s     = 1'b0;
        win_b_s     = 1'b0;
        last_step_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_a || req_b) begin
                    grant_s = 1'b1;
                    win_b_s = req_b && (!req_a || !last_grant_r);
                    state_s = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == CNT_W'(1)) begin
                    last_step_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s = CONV;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, handshake pulses and held display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            src_r        <= 1'b0;
            sign_lat_r   <= 1'b0;
            mag_r        <= '0;
            scr_r        <= '0;
            cnt_r        <= '0;
            ack_a        <= 1'b0;
            ack_b        <= 1'b0;
            done         <= 1'b0;
            bcd_digit    <= 10'd0;
            sign         <= 1'b0;
            overflow     <= 1'b0;
            disp_src     <= 1'b0;
        end else begin
            ack_a <= grant_s && !win_b_s;
            ack_b <= grant_s && win_b_s;
            done  <= last_step_s;
            if (grant_s) begin
                sign_lat_r   <= win_data_s[DATA_W-1];
                mag_r        <= abs_s;
                scr_r        <= '0;
                cnt_r        <= CNT_W'(DATA_W);
                last_grant_r <= win_b_s;
                src_r        <= win_b_s;
            end else if (state_r == CONV) begin
                scr_r <= shifted_s;
                mag_r <= {mag_r[DATA_W-2:0], 1'b0};
                cnt_r <= cnt_r - CNT_W'(1);
                if (last_step_s) begin
                    bcd_digit <= bcd_s;
                    sign      <= sign_lat_r;
                    overflow  <= ovf_s;
                    disp_src  <= src_r;
                end
            end
        end
    end

    assign busy = (state_r == CONV);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized scoreboard bench: stimulus predicts arbitration and pushes expected
// display results; an independent monitor checks them as done pulses arrive.
module tb_seg_display_arbiter;

    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_a = 1'b0, req_b = 1'b0;
    logic [DATA_W-1:0] data_a = '0, data_b = '0;
    logic              ack_a, ack_b, sign, overflow, disp_src, busy, done;
    logic [9:0]        bcd_digit;

    int  vectors = 0;
    int  errors = 0;
    bit  pa = 0, pb = 0, lg = 1, mon_en = 0;
    int  va = 0, vb = 0;
    logic [12:0] exp_q[$];

    seg_display_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .bcd_digit(bcd_digit), .sign(sign), .overflow(overflow),
        .disp_src(disp_src), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ref_out(input int v, input bit src);
        int m;
        bit s, o;
        s = (v < 0);
        m = s ? -v : v;
        o = (m > 399);
        if (o) m = 399;
        return {src, s, o, 2'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int rand_val();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 1000)) - 500;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic raise_a(input int v);
        int t;
        t = v;
        data_a = t[DATA_W-1:0];
        va = v; req_a = 1'b1; pa = 1;
    endtask

    task automatic raise_b(input int v);
        int t;
        t = v;
        data_b = t[DATA_W-1:0];
        vb = v; req_b = 1'b1; pb = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bcd"}, 32'(bcd_digit), 32'd0);
        check({tag, "_sign"}, 32'(sign), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_src"}, 32'(disp_src), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_acks"}, 32'({ack_a, ack_b}), 32'd0);
    endtask

    // Serve up to n grants; refill re-raises the winner, rnd adds random new requests.
    task automatic serve(input int n, input bit refill, input bit rnd);
        for (int k = 0; k < n && (pa || pb); k++) begin
            bit win;
            int t;
            win = (pa && pb) ? !lg : pb;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(ack_a || ack_b) && t < 60);
            if (!(ack_a || ack_b)) begin
                vectors++; errors++;
                $display("FAIL ack_timeout: got no ack, expected ack of %s", win ? "B" : "A");
                return;
            end
            check("arb_winner", 32'({ack_a, ack_b}), win ? 32'd1 : 32'd2);
            lg = win;
            exp_q.push_back(ref_out(win ? vb : va, win));
            if (win) begin
                pb = 0; req_b = 1'b0;
                if (refill) raise_b(rand_val());
            end else begin
                pa = 0; req_a = 1'b0;
                if (refill) raise_a(rand_val());
            end
            if (rnd && !pa && $urandom_range(0, 2) == 0) raise_a(rand_val());
            if (rnd && !pb && $urandom_range(0, 2) == 0) raise_b(rand_val());
        end
    endtask

    // Monitor: scoreboard compare on done, latency, single-cycle acks, output hold.
    initial begin
        logic [12:0] held, e;
        int lat;
        bit lat_on, pa_ack, pb_ack;
        held = '0; lat = 0; lat_on = 0; pa_ack = 0; pb_ack = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (rst) begin
                held = '0; lat_on = 0; pa_ack = 0; pb_ack = 0;
                continue;
            end
            if (lat_on) lat++;
            check("ack_a_single", 32'(ack_a && pa_ack), 32'd0);
            check("ack_b_single", 32'(ack_b && pb_ack), 32'd0);
            pa_ack = ack_a; pb_ack = ack_b;
            if (done) begin
                if (exp_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_done: got done, expected none pending");
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({disp_src, sign, overflow, bcd_digit}), 32'(e));
                    check("latency", 32'(lat), 32'(DATA_W));
                end
                held = {disp_src, sign, overflow, bcd_digit};
                lat_on = 0;
            end else begin
                check("hold", 32'({disp_src, sign, overflow, bcd_digit}), 32'(held));
            end
            if (ack_a || ack_b) begin
                lat_on = 1; lat = 0;
            end
        end
    end

    initial begin
        int t;
        #12 rst = 1'b1;
        #1 check_reset_outputs("reset");
        mon_en = 1;
        lg = 1;
        raise_a(rand_val());
        raise_b(rand_val());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        serve(4, 1, 0);
        serve(4, 0, 0);

        raise_a(123);   serve(1, 0, 0);
        raise_b(-57);   serve(1, 0, 0);
        raise_a(399);   serve(1, 0, 0);
        raise_b(400);   serve(1, 0, 0);
        raise_a(-2048); serve(1, 0, 0);
        raise_b(0);     serve(1, 0, 0);
        raise_a(-399);  serve(1, 0, 0);
        raise_b(2047);  serve(1, 0, 0);

        raise_a(321);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ack_a && t < 60);
        check("rst_test_ack", 32'(ack_a), 32'd1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        lg = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        serve(1, 0, 0);

        for (int r = 0; r < 60; r++) begin
            if (!pa && !pb) begin
                case ($urandom_range(0, 2))
                    0: raise_a(rand_val());
                    1: raise_b(rand_val());
                    default: begin
                        raise_a(rand_val());
                        raise_b(rand_val());
                    end
                endcase
            end
            serve(3, 0, 1);
        end
        serve(8, 0, 0);

        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
